// File: rtl/sprite_line_scanner_pkg.sv
// Shared constants for the sprite line scanner and the downstream descriptor splitter:
// field positions, geometry and scan FSM state encodings.
package sprite_line_scanner_pkg;

    localparam int NUM_SPRITES = 32;
    localparam int ADDR_W      = 5;
    localparam int Y_W         = 8;
    localparam int SPR_H       = 16;
    localparam int LINE_W      = 4;
    localparam int MAX_SLOTS   = 4;
    localparam int DESC_W      = 15;
    localparam int ATTR_W      = 19;

    // Descriptor layout {en, offset, line, num}
    localparam int DESC_NUM_LSB  = 0;
    localparam int DESC_NUM_MSB  = 4;
    localparam int DESC_LINE_LSB = 5;
    localparam int DESC_LINE_MSB = 8;
    localparam int DESC_OFS_LSB  = 9;
    localparam int DESC_OFS_MSB  = 13;
    localparam int DESC_EN_BIT   = 14;

    // Attribute RAM word layout
    localparam int ATTR_Y_LSB    = 0;
    localparam int ATTR_Y_MSB    = 7;
    localparam int ATTR_XOFF_LSB = 8;
    localparam int ATTR_XOFF_MSB = 12;
    localparam int ATTR_PAT_LSB  = 13;
    localparam int ATTR_PAT_MSB  = 17;
    localparam int ATTR_EN_BIT   = 18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } scan_state_e;

    typedef logic [DESC_W-1:0] desc_t;

    function automatic desc_t make_desc(input logic [4:0]        xoff,
                                        input logic [LINE_W-1:0] line,
                                        input logic [4:0]        pat);
        desc_t d;
        d = '0;
        d[DESC_EN_BIT]                  = 1'b1;
        d[DESC_OFS_MSB:DESC_OFS_LSB]   = xoff;
        d[DESC_LINE_MSB:DESC_LINE_LSB] = line;
        d[DESC_NUM_MSB:DESC_NUM_LSB]   = pat;
        return d;
    endfunction

endpackage

// File: rtl/sprite_line_scanner_hit_eval.sv
// Combinational vertical hit test for one attribute word against the current scanline,
// producing the descriptor that would be stored on a hit.
module sprite_hit_eval
    import sprite_line_scanner_pkg::*;
(
    input  logic [Y_W-1:0]    cur_y_i,
    input  logic [ATTR_W-1:0] attr_data_i,
    output logic              hit_o,
    output desc_t             desc_o
);

    logic [Y_W:0] diff;

    // One extra bit so a sprite below the line shows up as negative instead of wrapping.
    assign diff = {1'b0, cur_y_i} - {1'b0, attr_data_i[ATTR_Y_MSB:ATTR_Y_LSB]};

    assign hit_o = attr_data_i[ATTR_EN_BIT] && !diff[Y_W] && (diff < (Y_W+1)'(SPR_H));

    assign desc_o = make_desc(attr_data_i[ATTR_XOFF_MSB:ATTR_XOFF_LSB],
                              diff[LINE_W-1:0],
                              attr_data_i[ATTR_PAT_MSB:ATTR_PAT_LSB]);

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-scanline sprite evaluator: walks the attribute table once per line_start and
// publishes the first four vertically-covering sprites as descriptors.
module sprite_line_scanner
    import sprite_line_scanner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [Y_W-1:0]    line_y,
    output logic [ADDR_W-1:0] attr_addr,
    input  logic [ATTR_W-1:0] attr_data,
    output logic [DESC_W-1:0] sprite0,
    output logic [DESC_W-1:0] sprite1,
    output logic [DESC_W-1:0] sprite2,
    output logic [DESC_W-1:0] sprite3,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    scan_state_e                        state_q;
    logic [Y_W-1:0]                     cur_y_q;
    logic [ADDR_W-1:0]                  addr_q;
    logic                               issue_q;
    logic                               issue_last_q;
    logic                               data_vld_q;
    logic                               data_last_q;
    logic [MAX_SLOTS-1:0][DESC_W-1:0]   slot_q,  slot_d;
    logic [2:0]                         hit_cnt_q, hit_cnt_d;
    logic                               ovf_work_q, ovf_work_d;
    logic [MAX_SLOTS-1:0][DESC_W-1:0]   sprite_q;
    logic                               overflow_q;
    logic                               busy_q;
    logic                               done_q;

    logic  eval_hit;
    desc_t eval_desc;

    sprite_hit_eval u_hit_eval (
        .cur_y_i     (cur_y_q),
        .attr_data_i (attr_data),
        .hit_o       (eval_hit),
        .desc_o      (eval_desc)
    );

    // Slot fill: first hits take the lowest free slot, later ones only raise overflow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        slot_d     = slot_q;
        hit_cnt_d  = hit_cnt_q;
        ovf_work_d = ovf_work_q;
        if (data_vld_q && eval_hit) begin
            if (hit_cnt_q < 3'(MAX_SLOTS)) begin
                slot_d[hit_cnt_q[1:0]] = eval_desc;
                hit_cnt_d              = hit_cnt_q + 3'd1;
            end else begin
                ovf_work_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            // NOTE: the slot and output banks are plain flops, not RAM, so they are reset like any other state.
            state_q      <= ST_IDLE;
            cur_y_q      <= '0;
            addr_q       <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            data_vld_q   <= 1'b0;
            data_last_q  <= 1'b0;
            slot_q       <= '0;
            hit_cnt_q    <= '0;
            ovf_work_q   <= 1'b0;
            sprite_q     <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            slot_q      <= slot_d;
            hit_cnt_q   <= hit_cnt_d;
            ovf_work_q  <= ovf_work_d;
            data_vld_q  <= issue_q;
            data_last_q <= issue_last_q;

            case (state_q)
                ST_IDLE: begin
                    if (line_start) begin
                        cur_y_q      <= line_y;
                        slot_q       <= '0;
                        hit_cnt_q    <= '0;
                        ovf_work_q   <= 1'b0;
                        addr_q       <= '0;
                        issue_q      <= 1'b1;
                        issue_last_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (addr_q == ADDR_W'(NUM_SPRITES - 2)) begin
                        issue_last_q <= 1'b1;
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    issue_q      <= 1'b0;
                    issue_last_q <= 1'b0;
                    // The last read is evaluated on this edge; its result is in slot_d.
                    if (data_last_q) begin
                        state_q <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    sprite_q   <= slot_q;
                    overflow_q <= ovf_work_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign attr_addr = addr_q;
    assign sprite0   = sprite_q[0];
    assign sprite1   = sprite_q[1];
    assign sprite2   = sprite_q[2];
    assign sprite3   = sprite_q[3];
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Scoreboard bench for sprite_line_scanner: a reference model predicts each line's
// descriptors when line_start is driven; results are compared when done pulses.
module tb_sprite_line_scanner;
    import sprite_line_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [7:0]  line_y;
    logic [4:0]  attr_addr;
    logic [18:0] attr_data;
    logic [14:0] sprite0, sprite1, sprite2, sprite3;
    logic        overflow, busy, done;

    logic [18:0] mem [32];

    typedef struct packed {
        logic [3:0][14:0] spr;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    sprite_line_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_y     (line_y),
        .attr_addr  (attr_addr),
        .attr_data  (attr_data),
        .sprite0    (sprite0),
        .sprite1    (sprite1),
        .sprite2    (sprite2),
        .sprite3    (sprite3),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Attribute RAM with one cycle of read latency
    always @(posedge clk) attr_data <= mem[attr_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] attr(input logic [7:0] y, input logic [4:0] x,
                                         input logic [4:0] p, input logic en);
        return {en, p, x, y};
    endfunction

    function automatic exp_t model(input logic [7:0] y);
        exp_t       e;
        logic [2:0] cnt;
        logic [8:0] d;
        e   = '0;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            d = {1'b0, y} - {1'b0, mem[i][7:0]};
            if (mem[i][18] && !d[8] && d < 9'd16) begin
                if (cnt < 3'd4) begin
                    e.spr[cnt[1:0]] = {1'b1, mem[i][12:8], d[3:0], mem[i][17:13]};
                    cnt = cnt + 3'd1;
                end else begin
                    e.ovf = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 32; i++) mem[i] = '0;
    endtask

    // Starts one line; optionally pulses a second line_start dup_at edges into the scan.
    task automatic run_line(input logic [7:0] y, input int dup_at);
        exp_t e;
        int   n;
        bit   seen;
        int   extra;
        line_y     = y;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        line_y     = ~y;
        sb_q.push_back(model(y));
        n    = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == dup_at) begin
                line_start = 1'b1;
                line_y     = y + 8'd3;
            end else begin
                line_start = 1'b0;
            end
            if (n == 5) check("busy_mid", busy, 1);
            if (done) seen = 1'b1;
        end
        line_start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", n, 34);
        check("busy_at_done", busy, 0);
        e = sb_q.pop_front();
        check("sprite0", sprite0, e.spr[0]);
        check("sprite1", sprite1, e.spr[1]);
        check("sprite2", sprite2, e.spr[2]);
        check("sprite3", sprite3, e.spr[3]);
        check("overflow", overflow, e.ovf);
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("single_done", extra, 0);
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset state
        check("rst_sprite0", sprite0, 0);
        check("rst_sprite3", sprite3, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", attr_addr, 0);

        // Empty table
        run_line(8'd10, 0);
        check("empty_s0", sprite0, 0);

        // Single hit
        mem[3] = attr(8'd8, 5'd5, 5'd7, 1'b1);
        run_line(8'd10, 0);
        check("single_s0", sprite0, 15'h4A47);
        check("single_s1", sprite1, 0);

        // Six hits: first four by index, overflow set
        clear_table();
        foreach (mem[i]) begin
            if (i == 1 || i == 4 || i == 9 || i == 12 || i == 20 || i == 31)
                mem[i] = attr(8'd0, 5'(i), 5'(i), 1'b1);
        end
        run_line(8'd15, 0);
        check("ovf_num0", sprite0[4:0], 1);
        check("ovf_num1", sprite1[4:0], 4);
        check("ovf_num2", sprite2[4:0], 9);
        check("ovf_num3", sprite3[4:0], 12);
        check("ovf_line3", sprite3[8:5], 15);
        check("ovf_flag", overflow, 1);

        // Vertical boundaries around y=100 and no wrap from y=250
        clear_table();
        mem[7] = attr(8'd100, 5'd3, 5'd7, 1'b1);
        run_line(8'd99, 0);
        check("bnd_above", sprite0, 0);
        run_line(8'd100, 0);
        check("bnd_top_line", sprite0[8:5], 0);
        check("bnd_top_en", sprite0[14], 1);
        run_line(8'd115, 0);
        check("bnd_bot_line", sprite0[8:5], 15);
        run_line(8'd116, 0);
        check("bnd_below", sprite0, 0);
        clear_table();
        mem[0] = attr(8'd250, 5'd1, 5'd2, 1'b1);
        run_line(8'd2, 0);
        check("no_wrap", sprite0, 0);

        // Second line_start mid-scan is ignored
        mem[0] = attr(8'd0, 5'd9, 5'd17, 1'b1);
        mem[5] = attr(8'd10, 5'd2, 5'd3, 1'b1);
        run_line(8'd14, 10);
        check("dup_s1_line", sprite1[8:5], 4);

        // Reset mid-scan aborts without done and clears outputs
        line_y     = 8'd14;
        line_start = 1'b1;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_s0", sprite0, 0);
        check("abort_s1", sprite1, 0);
        check("abort_busy", busy, 0);

        // rst and line_start on the same edge: rst wins
        rst        = 1'b1;
        line_start = 1'b1;
        line_y     = 8'd14;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        line_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wins_busy", busy, 0);

        // Normal scan after the abort
        run_line(8'd14, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
